ysyx_23060075_axil_sram: RTL and testbench
==========================================

YSYX_23060075_AXIL_SRAM -- requirements
Module: ysyx_23060075_axil_sram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of araddr/awaddr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of rdata/wdata, 32 or 64; strobe width STRB_W = DATA_WIDTH/8.
REQ-003 SHALL have parameter DEPTH_LOG2, default 8: memory holds 2^DEPTH_LOG2 words.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h8000_0000: byte address of word 0.
REQ-005 SHALL have parameter FIX_DELAY, default 1 (range 1..15): fixed response latency in cycles.
REQ-006 SHALL have parameter MAX_DELAY, default 5 (range 1..15): upper bound of random latency.
REQ-007 clk  input  1  clock; all state changes on its rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 araddr in ADDR_WIDTH; arvalid in 1; arready out 1: read address channel.
REQ-010 rdata out DATA_WIDTH; rresp out 2; rvalid out 1; rready in 1: read data channel.
REQ-011 awaddr in ADDR_WIDTH; awvalid in 1; awready out 1: write address channel.
REQ-012 wdata in DATA_WIDTH; wstrb in STRB_W; wvalid in 1; wready out 1: write data channel.
REQ-013 bresp out 2; bvalid out 1; bready in 1: write response channel.

Function
REQ-014 Handshake on any channel SHALL occur on a rising edge where valid and ready are both 1.
REQ-015 Offset = addr - BASE_ADDR; in range iff offset < 2^DEPTH_LOG2 * STRB_W; word index = offset >> log2(STRB_W); low offset bits ignored.
REQ-016 Read FSM SHALL have states R_IDLE (arready=1), R_WAIT, R_RESP (rvalid=1); R_IDLE -> R_WAIT on AR handshake, capturing address and loading delay D.
REQ-017 R_WAIT SHALL decrement the counter each cycle and enter R_RESP exactly D cycles after the AR handshake, registering rdata and rresp on that edge.
REQ-018 R_RESP SHALL hold rdata/rresp stable until R handshake, then return to R_IDLE; arready SHALL reassert on the following cycle, never while rvalid=1.
REQ-019 In-range read: rresp=2'b00, rdata=stored word; out-of-range: rresp=2'b10 (SLVERR), rdata=0.
REQ-020 Write FSM SHALL accept AW and W independently in W_IDLE (awready/wready each deassert after own handshake), same-cycle acceptance of both allowed, arrival order free.
REQ-021 When both AW and W are captured, write SHALL wait D cycles, then commit to memory and assert bvalid on the same edge; bvalid held until B handshake; awready and wready reassert the following cycle.
REQ-022 Commit SHALL update only bytes whose wstrb bit is 1; in-range: bresp=2'b00; out-of-range: no memory change, bresp=2'b10.
REQ-023 Read and write channels SHALL operate concurrently; if read data is registered on the same edge a write commits to that word, the read SHALL return pre-write data.
REQ-024 At most one read and one write SHALL be outstanding.

Reset
REQ-025 On rst: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0, FSMs idle, counters 0, LFSR=8'hA5.
REQ-026 Reset mid-transaction SHALL abandon it with no memory write; memory contents SHALL NOT be reset.

Configuration
REQ-027 Macro YSYX_23060075_SRAM_RAND_DELAY_EN defined: D = (lfsr mod MAX_DELAY) + 1, sampled at AR handshake (reads) or at capture of the second of AW/W (writes); 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, advancing every cycle.
REQ-028 Macro undefined: D = FIX_DELAY for all transactions; no LFSR logic instantiated.

Verification (defaults, macro undefined)
REQ-029 AW 0x8000_0010 + W 0xDEADBEEF strb 4'hF same cycle -> bvalid 1 cycle later, bresp 0; read 0x8000_0010 -> rvalid 1 cycle after AR, rdata 0xDEADBEEF, rresp 0.
REQ-030 Then write 0x0000AA00 strb 4'b0010 to 0x8000_0012 -> read 0x8000_0010 returns 0xDEADAAEF.
REQ-031 Write/read at 0x8000_0400 -> bresp 2'b10, memory unchanged; rdata 0, rresp 2'b10.
REQ-032 W presented 3 cycles before AW -> wready drops after W handshake, bvalid exactly 1 cycle after AW handshake, data written.
REQ-033 rready held 0 for 5 cycles after rvalid -> rvalid, rdata stable, arready 0 throughout; arready 1 cycle after R handshake.
REQ-034 rst pulsed while write in W_WAIT -> all outputs at reset values, subsequent read of target word returns prior contents.

Source files
------------

// File: rtl/ysyx_23060075_axil_sram.sv
// AXI4-Lite slave SRAM model with a configurable response latency.
//
// The read channel and the write channel each run their own FSM and work
// concurrently. Each allows at most one outstanding transaction. Every
// transaction waits D cycles and then responds.
//
// Configuration macro YSYX_23060075_SRAM_RAND_DELAY_EN:
//   - defined:   D = (lfsr mod MAX_DELAY) + 1. The LFSR is an 8-bit Fibonacci
//                LFSR, x^8+x^6+x^5+x^4+1, seeded with 8'hA5 and advancing
//                every cycle.
//   - undefined: D = FIX_DELAY for every transaction.
//
// Ports:
//   clk, rst                          clock; asynchronous active-high reset
//   araddr/arvalid/arready            read address channel
//   rdata/rresp/rvalid/rready         read data channel
//   awaddr/awvalid/awready            write address channel
//   wdata/wstrb/wvalid/wready         write data channel
//   bresp/bvalid/bready               write response channel
module ysyx_23060075_axil_sram #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          FIX_DELAY  = 1,
    parameter int          MAX_DELAY  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [ADDR_WIDTH:0]   LIMIT = (ADDR_WIDTH+1)'(DEPTH * STRB_W);
    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);

    if (FIX_DELAY < 1 || FIX_DELAY > 15 || MAX_DELAY < 1 || MAX_DELAY > 15) begin : g_bad_delay
        $error("FIX_DELAY and MAX_DELAY must lie in 1..15");
    end

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [3:0] delay_d;

`ifdef YSYX_23060075_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= 8'hA5;
        else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign delay_d = 4'((32'(lfsr) % 32'(MAX_DELAY)) + 32'd1);
`else
    assign delay_d = 4'(FIX_DELAY);
`endif

    // ---------------- read channel ----------------
    r_state_t              r_state, r_state_n;
    logic [3:0]            r_cnt, r_cnt_n;
    logic                  r_fire;
    logic [ADDR_WIDTH-1:0] r_addr, r_off;
    logic                  r_hit;

    assign r_off = r_addr - BASE;
    assign r_hit = {1'b0, r_off} < LIMIT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= r_state_n;
            r_cnt   <= r_cnt_n;
        end
    end

    always_comb begin
        r_state_n = r_state;
        r_cnt_n   = r_cnt;
        arready   = 1'b0;
        rvalid    = 1'b0;
        r_fire    = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    r_state_n = R_WAIT;
                    r_cnt_n   = delay_d;
                end
            end
            R_WAIT: begin
                // The last wait cycle is the one whose edge registers the data.
                if (r_cnt <= 4'd1) begin
                    r_state_n = R_RESP;
                    r_cnt_n   = '0;
                    r_fire    = 1'b1;
                end else begin
                    r_cnt_n = r_cnt - 4'd1;
                end
            end
            R_RESP: begin
                rvalid = 1'b1;
                if (rready) r_state_n = R_IDLE;
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arready && arvalid) r_addr <= araddr;
    end

    // A commit to the same word on this edge is not visible here, so the read
    // returns the pre-write contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
            rresp <= 2'b00;
        end else if (r_fire) begin
            rdata <= r_hit ? mem[r_off[OFF_W +: DEPTH_LOG2]] : '0;
            rresp <= r_hit ? 2'b00 : 2'b10;
        end
    end

    // ---------------- write channel ----------------
    w_state_t              w_state, w_state_n;
    logic [3:0]            w_cnt, w_cnt_n;
    logic                  aw_got, aw_got_n, w_got, w_got_n;
    logic                  aw_hs, w_hs, w_commit;
    logic [ADDR_WIDTH-1:0] w_addr, w_off;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic                  w_hit;

    assign w_off = w_addr - BASE;
    assign w_hit = {1'b0, w_off} < LIMIT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_cnt   <= '0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
        end else begin
            w_state <= w_state_n;
            w_cnt   <= w_cnt_n;
            aw_got  <= aw_got_n;
            w_got   <= w_got_n;
        end
    end

    always_comb begin
        w_state_n = w_state;
        w_cnt_n   = w_cnt;
        aw_got_n  = aw_got;
        w_got_n   = w_got;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        w_commit  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready  = !aw_got;
                wready   = !w_got;
                aw_hs    = awready && awvalid;
                w_hs     = wready && wvalid;
                aw_got_n = aw_got || aw_hs;
                w_got_n  = w_got || w_hs;
                // The delay starts once both halves of the request are held.
                if (aw_got_n && w_got_n) begin
                    w_state_n = W_WAIT;
                    w_cnt_n   = delay_d;
                    aw_got_n  = 1'b0;
                    w_got_n   = 1'b0;
                end
            end
            W_WAIT: begin
                if (w_cnt <= 4'd1) begin
                    w_state_n = W_RESP;
                    w_cnt_n   = '0;
                    w_commit  = 1'b1;
                end else begin
                    w_cnt_n = w_cnt - 4'd1;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_state_n = W_IDLE;
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (aw_hs) w_addr <= awaddr;
        if (w_hs) begin
            w_data <= wdata;
            w_strb <= wstrb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           bresp <= 2'b00;
        else if (w_commit) bresp <= w_hit ? 2'b00 : 2'b10;
    end

    // Memory is never reset. A reset aborts the FSM, so no commit follows it.
    always_ff @(posedge clk) begin
        if (w_commit && w_hit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) mem[w_off[OFF_W +: DEPTH_LOG2]][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060075_axil_sram.sv
module tb_ysyx_23060075_axil_sram;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_23060075_axil_sram dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] exp_resp);
        int lat;
        @(negedge clk);
        check({tag, "_aw_w_ready"}, 64'(awready & wready), 64'd1);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_b_latency"}, 64'(lat), 64'd1);
        check({tag, "_bresp"}, 64'(bresp), 64'(exp_resp));
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check({tag, "_bvalid_drop"}, 64'(bvalid), 64'd0);
        check({tag, "_ready_back"}, 64'(awready & wready), 64'd1);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int lat;
        @(negedge clk);
        check({tag, "_arready"}, 64'(arready), 64'd1);
        araddr = a; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_r_latency"}, 64'(lat), 64'd1);
        check({tag, "_rdata"}, 64'(rdata), 64'(exp_data));
        check({tag, "_rresp"}, 64'(rresp), 64'(exp_resp));
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check({tag, "_arready_back"}, 64'(arready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arready"}, 64'(arready), 64'd1);
        check({tag, "_awready"}, 64'(awready), 64'd1);
        check({tag, "_wready"},  64'(wready),  64'd1);
        check({tag, "_rvalid"},  64'(rvalid),  64'd0);
        check({tag, "_bvalid"},  64'(bvalid),  64'd0);
        check({tag, "_rdata"},   64'(rdata),   64'd0);
        check({tag, "_rresp"},   64'(rresp),   64'd0);
        check({tag, "_bresp"},   64'(bresp),   64'd0);
    endtask

    initial begin
        int lat;
        vecs[0]  = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 32'h0,         2'b00};
        vecs[1]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
        vecs[2]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
        vecs[3]  = '{1'b1, 32'h8000_0012, 32'h0000_AA00, 4'h2, 32'h0,         2'b00};
        vecs[4]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_AAEF, 2'b00};
        vecs[5]  = '{1'b1, 32'h8000_0400, 32'h1234_5678, 4'hF, 32'h0,         2'b10};
        vecs[6]  = '{1'b0, 32'h8000_0400, 32'h0,         4'h0, 32'h0,         2'b10};
        vecs[7]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 2'b00};
        vecs[8]  = '{1'b1, 32'h8000_03FC, 32'h1122_3344, 4'hF, 32'h0,         2'b00};
        vecs[9]  = '{1'b0, 32'h8000_03FF, 32'h0,         4'h0, 32'h1122_3344, 2'b00};
        vecs[10] = '{1'b1, 32'h7FFF_FFFC, 32'h5555_5555, 4'hF, 32'h0,         2'b10};
        vecs[11] = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         2'b10};
        vecs[12] = '{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'hF, 32'h0,         2'b00};
        vecs[13] = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'h9, 32'h0,         2'b00};
        vecs[14] = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'h11BB_CC44, 2'b00};
        vecs[15] = '{1'b0, 32'h8000_03FC, 32'h0,         4'h0, 32'h1122_3344, 2'b00};

        // reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // table-driven single transactions
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr)
                do_write($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
            else
                do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
        end

        // W arrives three cycles ahead of AW
        @(negedge clk);
        wdata = 32'h5A5A_5A5A; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        check("early_w_wready_drop", 64'(wready), 64'd0);
        check("early_w_awready", 64'(awready), 64'd1);
        repeat (2) @(negedge clk);
        check("early_w_wready_held", 64'(wready), 64'd0);
        check("early_w_no_bvalid", 64'(bvalid), 64'd0);
        awaddr = 32'h8000_0030; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("early_w_b_latency", 64'(lat), 64'd1);
        check("early_w_bresp", 64'(bresp), 64'd0);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("early_w_wready_back", 64'(wready), 64'd1);
        do_read("early_w_rd", 32'h8000_0030, 32'h5A5A_5A5A, 2'b00);

        // read response stalled by rready=0 for five cycles
        do_write("stall_wr", 32'h8000_0040, 32'h1357_9BDF, 4'hF, 2'b00);
        @(negedge clk);
        araddr = 32'h8000_0040; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("stall_r_latency", 64'(lat), 64'd1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall_rvalid_%0d", k), 64'(rvalid), 64'd1);
            check($sformatf("stall_rdata_%0d", k), 64'(rdata), 64'h1357_9BDF);
            check($sformatf("stall_arready_%0d", k), 64'(arready), 64'd0);
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("stall_rvalid_drop", 64'(rvalid), 64'd0);
        check("stall_arready_back", 64'(arready), 64'd1);

        // read and write of the same word completing on the same edge
        do_write("coll_init", 32'h8000_0050, 32'h0BAD_F00D, 4'hF, 2'b00);
        @(negedge clk);
        araddr = 32'h8000_0050; arvalid = 1'b1;
        awaddr = 32'h8000_0050; wdata = 32'h600D_CAFE; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("coll_rvalid", 64'(rvalid), 64'd1);
        check("coll_bvalid", 64'(bvalid), 64'd1);
        check("coll_old_data", 64'(rdata), 64'h0BAD_F00D);
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        do_read("coll_new", 32'h8000_0050, 32'h600D_CAFE, 2'b00);

        // reset while a write is waiting to commit
        do_write("pre_rst_oor", 32'h8000_0400, 32'hFFFF_FFFF, 4'hF, 2'b10);
        do_read("pre_rst_rd", 32'h8000_0040, 32'h1357_9BDF, 2'b00);
        @(negedge clk);
        awaddr = 32'h8000_0010; wdata = 32'h0101_0101; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        check("midrst_no_bvalid", 64'(bvalid), 64'd0);
        do_read("midrst_rd", 32'h8000_0010, 32'hDEAD_AAEF, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
